// File: rtl/blood_ph_monitor.sv
// rtl/blood_ph_monitor.sv - persistence-filtered blood pH out-of-band alarm
//
// Purpose: classifies each valid pH sample as normal (LOW_TH..HIGH_TH inclusive)
//   or abnormal, and only raises or drops the alarm after PERSIST consecutive
//   samples that disagree with the current alarm status.
// Ports:
//   clk          - rising-edge clock
//   rst          - asynchronous active-high reset
//   sample_valid - bloodPH carries a new sample this cycle
//   bloodPH      - unsigned pH code, PH_W bits
//   clear        - synchronous clear of state and counters (beats sample_valid)
//   abnormalityP - filtered alarm (state ALARM or RECOVER)
//   abnormalityQ - alarm cause: 1 acidic, 0 alkaline; 0 while no alarm
//   state        - FSM code: NORMAL 00, SUSPECT 01, ALARM 10, RECOVER 11
//   alarm_events - saturating count of entries into ALARM from NORMAL/SUSPECT
module blood_ph_monitor #(
  parameter int PH_W    = 4,
  parameter int LOW_TH  = 6,
  parameter int HIGH_TH = 8,
  parameter int PERSIST = 3,
  parameter int EVT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_valid,
  input  logic [PH_W-1:0]  bloodPH,
  input  logic             clear,
  output logic             abnormalityP,
  output logic             abnormalityQ,
  output logic [1:0]       state,
  output logic [EVT_W-1:0] alarm_events
);

  typedef enum logic [1:0] {
    ST_NORMAL  = 2'b00,
    ST_SUSPECT = 2'b01,
    ST_ALARM   = 2'b10,
    ST_RECOVER = 2'b11
  } state_t;

  localparam logic [PH_W-1:0] LOW_C     = PH_W'(LOW_TH);
  localparam logic [PH_W-1:0] HIGH_C    = PH_W'(HIGH_TH);
  localparam logic [3:0]      PERSIST_C = 4'(PERSIST);

  state_t             st;
  logic [3:0]         run;
  logic [3:0]         run_inc;
  logic               acidic;
  logic               abnormal;
  logic [EVT_W-1:0]   events_sat;

  assign acidic     = bloodPH < LOW_C;
  assign abnormal   = acidic || (bloodPH > HIGH_C);
  assign run_inc    = run + 4'd1;
  // Counter holds at all-ones instead of wrapping.
  assign events_sat = (alarm_events == {EVT_W{1'b1}}) ? alarm_events
                                                      : alarm_events + 1'b1;
  assign state      = st;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st           <= ST_NORMAL;
      run          <= 4'd0;
      abnormalityP <= 1'b0;
      abnormalityQ <= 1'b0;
      alarm_events <= '0;
    end else if (clear) begin
      st           <= ST_NORMAL;
      run          <= 4'd0;
      abnormalityP <= 1'b0;
      abnormalityQ <= 1'b0;
      alarm_events <= '0;
    end else if (sample_valid) begin
      case (st)
        ST_NORMAL: begin
          if (abnormal) begin
            if (PERSIST == 1) begin
              st           <= ST_ALARM;
              run          <= 4'd0;
              abnormalityP <= 1'b1;
              abnormalityQ <= acidic;
              alarm_events <= events_sat;
            end else begin
              st  <= ST_SUSPECT;
              run <= 4'd1;
            end
          end
        end
        ST_SUSPECT: begin
          if (abnormal) begin
            if (run_inc == PERSIST_C) begin
              st           <= ST_ALARM;
              run          <= 4'd0;
              abnormalityP <= 1'b1;
              abnormalityQ <= acidic;
              alarm_events <= events_sat;
            end else begin
              run <= run_inc;
            end
          end else begin
            st  <= ST_NORMAL;
            run <= 4'd0;
          end
        end
        ST_ALARM: begin
          if (abnormal) begin
            // Cause tracks the most recent abnormal sample.
            abnormalityQ <= acidic;
          end else if (PERSIST == 1) begin
            st           <= ST_NORMAL;
            run          <= 4'd0;
            abnormalityP <= 1'b0;
            abnormalityQ <= 1'b0;
          end else begin
            st  <= ST_RECOVER;
            run <= 4'd1;
          end
        end
        default: begin  // ST_RECOVER
          if (abnormal) begin
            // Relapse: back to ALARM without counting a new event.
            st           <= ST_ALARM;
            run          <= 4'd0;
            abnormalityQ <= acidic;
          end else if (run_inc == PERSIST_C) begin
            st           <= ST_NORMAL;
            run          <= 4'd0;
            abnormalityP <= 1'b0;
            abnormalityQ <= 1'b0;
          end else begin
            run <= run_inc;
          end
        end
      endcase
    end
  end

endmodule
